// File: rtl/cpu_decode_pkg.sv
// cpu_decode_pkg: moxie decode opcode constants and FSM state encoding
package cpu_decode_pkg;
  localparam logic [7:0] OPC_LDI_L = 8'h01;
  localparam logic [7:0] OPC_NOP   = 8'h0f;
  localparam logic [3:0] FORM2_DEC = 4'b1001;
  typedef enum logic [1:0] {S_OP, S_IMM0, S_IMM1} state_e;
endpackage

// File: rtl/cpu_decode_classify.sv
// cpu_decode_classify: combinational opcode classification (is_illegal_o only with CPU_DECODE_ILLEGAL_EN)
module cpu_decode_classify
  import cpu_decode_pkg::*;
(
  input  logic [15:0] insn_i,
  output logic        is_ldi_o,
  output logic        is_dec_o,
  output logic        is_nop_o,
`ifdef CPU_DECODE_ILLEGAL_EN
  output logic        is_illegal_o,
`endif
  output logic [3:0]  ra_o,
  output logic [7:0]  imm8_o
);
  // decode the opcode fields; dec carries its register in a different nibble than ldi.l
  always_comb begin
    is_ldi_o = insn_i[15:8] == OPC_LDI_L;
    is_nop_o = insn_i[15:8] == OPC_NOP;
    is_dec_o = insn_i[15:12] == FORM2_DEC;
`ifdef CPU_DECODE_ILLEGAL_EN
    is_illegal_o = ~(is_ldi_o | is_nop_o | is_dec_o);
`endif
    ra_o = is_dec_o ? insn_i[11:8] : insn_i[7:4];
    imm8_o = insn_i[7:0];
  end
endmodule

// File: rtl/cpu_decode.sv
// cpu_decode: moxie decode stage, ldi.l/dec/nop strobes (op_illegal_o with CPU_DECODE_ILLEGAL_EN)
module cpu_decode
  import cpu_decode_pkg::*;
#(
  parameter int IMM_BIG_ENDIAN = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] insn_i,
  input  logic        insn_valid_i,
  output logic        insn_ready_o,
  input  logic        flush_i,
  output logic        op_ldi_o,
  output logic        op_dec_o,
  output logic        op_nop_o,
  output logic [3:0]  register_write_index_o,
  output logic [3:0]  register_read_index_o,
  output logic [31:0] operand_o
`ifdef CPU_DECODE_ILLEGAL_EN
  ,
  output logic        op_illegal_o
`endif
);
  state_e      state_q, state_d;
  logic        ready_q, ldi_q, ldi_d, dec_q, dec_d, nop_q, nop_d;
  logic [3:0]  wr_q, wr_d, rd_q, rd_d, ra_q, ra_d;
  logic [15:0] imm0_q, imm0_d;
  logic [31:0] operand_q, operand_d;
  logic        is_ldi, is_dec, is_nop, acc;
  logic [3:0]  ra;
  logic [7:0]  imm8;
`ifdef CPU_DECODE_ILLEGAL_EN
  logic        is_illegal, illegal_q, illegal_d;
`endif
  cpu_decode_classify u_classify (
    .insn_i       (insn_i),
    .is_ldi_o     (is_ldi),
    .is_dec_o     (is_dec),
    .is_nop_o     (is_nop),
`ifdef CPU_DECODE_ILLEGAL_EN
    .is_illegal_o (is_illegal),
`endif
    .ra_o         (ra),
    .imm8_o       (imm8)
  );
  assign acc = insn_valid_i & ready_q & ~flush_i;
  // next-state and next-output: flush drops the halfword, immediates are never decoded as opcodes
  always_comb begin
    state_d = state_q;
    ldi_d = 1'b0;
    dec_d = 1'b0;
    nop_d = 1'b1;
    wr_d = wr_q;
    rd_d = rd_q;
    ra_d = ra_q;
    imm0_d = imm0_q;
    operand_d = operand_q;
`ifdef CPU_DECODE_ILLEGAL_EN
    illegal_d = 1'b0;
`endif
    if (flush_i) state_d = S_OP;
    else if (acc) begin
      case (state_q)
        S_OP: begin
          state_d = is_ldi ? S_IMM0 : S_OP;
          ra_d = is_ldi ? ra : ra_q;
          dec_d = is_dec;
          nop_d = ~is_dec;
          wr_d = is_dec ? ra : wr_q;
          rd_d = is_dec ? ra : rd_q;
          operand_d = is_dec ? {24'b0, imm8} : operand_q;
`ifdef CPU_DECODE_ILLEGAL_EN
          illegal_d = is_illegal;
`endif
        end
        S_IMM0: begin
          imm0_d = insn_i;
          state_d = S_IMM1;
        end
        S_IMM1: begin
          ldi_d = 1'b1;
          nop_d = 1'b0;
          wr_d = ra_q;
          operand_d = IMM_BIG_ENDIAN != 0 ? {imm0_q, insn_i} : {insn_i, imm0_q};
          state_d = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end
  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_OP;
      ready_q <= 1'b0;
      ldi_q <= 1'b0;
      dec_q <= 1'b0;
      nop_q <= 1'b1;
      wr_q <= 4'd0;
      rd_q <= 4'd0;
      ra_q <= 4'd0;
      imm0_q <= 16'd0;
      operand_q <= 32'd0;
`ifdef CPU_DECODE_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      ldi_q <= ldi_d;
      dec_q <= dec_d;
      nop_q <= nop_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ra_q <= ra_d;
      imm0_q <= imm0_d;
      operand_q <= operand_d;
`ifdef CPU_DECODE_ILLEGAL_EN
      illegal_q <= illegal_d;
`endif
    end
  end
  assign insn_ready_o = ready_q;
  assign op_ldi_o = ldi_q;
  assign op_dec_o = dec_q;
  assign op_nop_o = nop_q;
  assign register_write_index_o = wr_q;
  assign register_read_index_o = rd_q;
  assign operand_o = operand_q;
`ifdef CPU_DECODE_ILLEGAL_EN
  assign op_illegal_o = illegal_q;
`endif
endmodule

// File: tb/tb_cpu_decode.sv
// tb_cpu_decode: vector table, reset sequences and random run against a halfword-queue model
module tb_cpu_decode;
  localparam int BE = 1;
  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] insn_i = 16'd0;
  logic        insn_valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        insn_ready_o, op_ldi_o, op_dec_o, op_nop_o;
  logic [3:0]  register_write_index_o, register_read_index_o;
  logic [31:0] operand_o;
`ifdef CPU_DECODE_ILLEGAL_EN
  logic        op_illegal_o;
`endif
  int n_chk = 0;
  int n_fail = 0;
  cpu_decode #(.IMM_BIG_ENDIAN(BE)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .insn_i                 (insn_i),
    .insn_valid_i           (insn_valid_i),
    .insn_ready_o           (insn_ready_o),
    .flush_i                (flush_i),
    .op_ldi_o               (op_ldi_o),
    .op_dec_o               (op_dec_o),
    .op_nop_o               (op_nop_o),
    .register_write_index_o (register_write_index_o),
    .register_read_index_o  (register_read_index_o),
    .operand_o              (operand_o)
`ifdef CPU_DECODE_ILLEGAL_EN
    ,
    .op_illegal_o           (op_illegal_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] insn;
    bit v, f, e_ldi, e_dec;
    logic [3:0] e_wr;
    logic [31:0] e_op;
    bit e_ill;
  } vec_t;
  vec_t tv[$];
  logic [15:0] pend[$];
  bit m_ready = 0, m_ldi = 0, m_dec = 0, m_ill = 0;
  logic [3:0] m_wr = 0, m_rd = 0;
  logic [31:0] m_op = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: halfwords of an ldi.l are queued until three are held; anything else is decoded alone
  task automatic model(input logic [15:0] insn, input bit v, input bit f, input bit r);
    m_ldi = 0; m_dec = 0; m_ill = 0;
    if (!r) begin
      pend.delete(); m_ready = 0; m_wr = 0; m_rd = 0; m_op = 0;
      return;
    end
    if (f) pend.delete();
    else if (v && m_ready) begin
      if (pend.size() == 0) begin
        if (insn[15:8] == 8'h01) pend.push_back(insn);
        else if (insn[15:12] == 4'h9) begin
          m_dec = 1; m_wr = insn[11:8]; m_rd = insn[11:8]; m_op = 32'(insn[7:0]);
        end else m_ill = insn[15:8] != 8'h0f;
      end else begin
        pend.push_back(insn);
        if (pend.size() == 3) begin
          m_ldi = 1; m_wr = pend[0][7:4];
          m_op = BE != 0 ? {pend[1], pend[2]} : {pend[2], pend[1]};
          pend.delete();
        end
      end
    end
    m_ready = 1;
  endtask
  task automatic step(input logic [15:0] insn, input bit v, input bit f, input bit r);
    insn_i = insn; insn_valid_i = v; flush_i = f; rst_i = r;
    model(insn, v, f, r);
    @(posedge clk);
    #1;
  endtask
  task automatic check_model(input string tag);
    check({tag, " ldi"}, op_ldi_o, m_ldi);
    check({tag, " dec"}, op_dec_o, m_dec);
    check({tag, " nop"}, op_nop_o, !(m_ldi || m_dec));
    check({tag, " wr"}, register_write_index_o, m_wr);
    check({tag, " rd"}, register_read_index_o, m_rd);
    check({tag, " operand"}, operand_o, m_op);
    check({tag, " ready"}, insn_ready_o, m_ready);
`ifdef CPU_DECODE_ILLEGAL_EN
    check({tag, " illegal"}, op_illegal_o, m_ill);
`endif
  endtask
  initial begin
    tv.push_back(vec_t'{16'h9305, 1, 0, 0, 1, 4'd3, 32'h5, 0});
    tv.push_back(vec_t'{16'h0120, 1, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'hDEAD, 1, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'hBEEF, 1, 0, 1, 0, 4'd2, 32'hDEADBEEF, 0});
    tv.push_back(vec_t'{16'h0170, 1, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'h5555, 0, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'h1234, 1, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'h0000, 0, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'h0f01, 1, 0, 1, 0, 4'd7, 32'h12340f01, 0});
    tv.push_back(vec_t'{16'h0120, 1, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'hDEAD, 1, 1, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'h9101, 1, 0, 0, 1, 4'd1, 32'h1, 0});
    tv.push_back(vec_t'{16'h0120, 1, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'h1111, 1, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'h2222, 1, 1, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'h9a10, 1, 0, 0, 1, 4'd10, 32'h10, 0});
    tv.push_back(vec_t'{16'h0f00, 1, 0, 0, 0, 4'd0, 32'h0, 0});
    tv.push_back(vec_t'{16'h2200, 1, 0, 0, 0, 4'd0, 32'h0, 1});
    tv.push_back(vec_t'{16'h0f00, 1, 0, 0, 0, 4'd0, 32'h0, 0});
    for (int i = 0; i < 3; i++) begin
      step(16'h0120, 1, 0, 0);
      check("rst nop", op_nop_o, 1);
      check("rst ready", insn_ready_o, 0);
      check("rst operand", operand_o, 0);
      check("rst strobes", {op_ldi_o, op_dec_o}, 0);
    end
    step(16'h0000, 0, 0, 1);
    check("release ready", insn_ready_o, 1);
    check("release nop", op_nop_o, 1);
    check("release wr", register_write_index_o, 0);
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].insn, tv[i].v, tv[i].f, 1);
      check($sformatf("tv%0d ldi", i), op_ldi_o, tv[i].e_ldi);
      check($sformatf("tv%0d dec", i), op_dec_o, tv[i].e_dec);
      check($sformatf("tv%0d nop", i), op_nop_o, !(tv[i].e_ldi || tv[i].e_dec));
      if (tv[i].e_ldi || tv[i].e_dec) begin
        check($sformatf("tv%0d wr", i), register_write_index_o, tv[i].e_wr);
        check($sformatf("tv%0d operand", i), operand_o, tv[i].e_op);
      end
      if (tv[i].e_dec) check($sformatf("tv%0d rd", i), register_read_index_o, tv[i].e_wr);
`ifdef CPU_DECODE_ILLEGAL_EN
      check($sformatf("tv%0d illegal", i), op_illegal_o, tv[i].e_ill);
`endif
    end
    step(16'h0120, 1, 0, 1);
    step(16'h1111, 1, 0, 1);
    step(16'h0000, 0, 0, 0);
    check("midrst nop", op_nop_o, 1);
    check("midrst operand", operand_o, 0);
    check("midrst wr", register_write_index_o, 0);
    check("midrst ready", insn_ready_o, 0);
    step(16'h2222, 1, 0, 1);
    check("midrst ignored nop", op_nop_o, 1);
    step(16'h0f00, 1, 0, 1);
    check("midrst opcode nop", op_nop_o, 1);
    step(16'h9305, 1, 0, 1);
    check("midrst dec", op_dec_o, 1);
    check("midrst dec ldi", op_ldi_o, 0);
    check("midrst dec operand", operand_o, 32'h5);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] h;
      h = 16'($urandom);
      case ($urandom_range(0, 4))
        0: h = {8'h01, h[7:0]};
        1: h = {4'h9, h[11:0]};
        2: h = {8'h0f, h[7:0]};
        default: ;
      endcase
      step(h, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
      check_model($sformatf("rnd%0d", i));
      check($sformatf("rnd%0d onehot", i), $countones({op_ldi_o, op_dec_o, op_nop_o}), 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
